// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding and the default operand width.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_bit_cell.sv
// Combinational 1-bit add/sub cell. With sel=1, b is inverted so the
// cell performs the two's-complement step of a - b.
module addsub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sel,
  output logic sum,
  output logic cout
);

  logic w_bx;

  assign w_bx = b ^ sel;
  assign sum  = a ^ w_bx ^ cin;
  assign cout = (a & w_bx) | (a & cin) | (w_bx & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one add/sub cell is reused
// for WIDTH cycles, LSB first, with a start/done handshake.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_shadow;
  logic               r_sub;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_shadow_next;
  logic               w_last_bit;

  addsub_bit_cell u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sel  (r_sub),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_shadow_next = {w_sum, r_shadow[WIDTH-1:1]};
  assign w_last_bit    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new request exactly like IDLE (back-to-back ops).
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_sub    <= sub;
            r_carry  <= sub;
            r_cnt    <= '0;
            r_shadow <= '0;
            busy     <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_shadow <= w_shadow_next;
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          // On the MSB step r_carry is the carry into the MSB.
          if (w_last_bit) begin
            result   <= w_shadow_next;
            cout     <= w_cout;
            overflow <= r_carry ^ w_cout;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
